// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
// All segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_POS = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,
    7'b1111001,
    7'b0100100,
    7'b0110000,
    7'b0011001,
    7'b0010010,
    7'b0000010,
    7'b1111000,
    7'b0000000,
    7'b0010000
  };

  typedef logic [$clog2(NUM_POS)-1:0] pos_t;

  typedef struct packed {
    logic        sign;
    logic [19:0] digits;
  } bcd_value_t;

  // Position 5 is the sign slot and carries no digit.
  function automatic logic [3:0] digit_at(input logic [19:0] digits, input pos_t p);
    logic [3:0] d;
    case (p)
      3'd0:    d = digits[3:0];
      3'd1:    d = digits[7:4];
      3'd2:    d = digits[11:8];
      3'd3:    d = digits[15:12];
      3'd4:    d = digits[19:16];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_7seg_scan_if.sv
// Valid/ready handshake carrying a signed five-digit BCD value into the scanner.
interface bcd_7seg_scan_if;

  logic        in_valid;
  logic        in_ready;
  logic        negative;
  logic [19:0] digits;

  modport master (
    output in_valid,
    output negative,
    output digits,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  negative,
    input  digits,
    output in_ready
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment pattern; non-decimal codes show E.
module bcd_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Six-position multiplexed display driver with a double-buffered value that is
// only committed at frame boundaries, leading-zero blanking and a sign position.
module bcd_7seg_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic           clk,
  input  logic           reset,
  bcd_7seg_scan_if.slave bus,
  input  logic           blank_lz,
  output logic [5:0]     an,
  output logic [6:0]     seg
);

  localparam pos_t LAST_POS = pos_t'(NUM_POS - 1);

  logic [15:0] prescaler;
  logic        tick;
  logic        scanning;
  pos_t        pos;
  pos_t        pos_next;
  logic        pend;
  bcd_value_t  pend_val;
  bcd_value_t  disp_val;
  bcd_value_t  show_val;
  logic        commit;
  logic [3:0]  cur_digit;
  logic [6:0]  digit_seg;
  logic [6:0]  seg_next;
  logic [5:0]  an_next;
  logic [4:0]  lead_zero;

  assign tick         = (prescaler == 16'(CLK_DIV - 1));
  assign commit       = tick && scanning && (pos == LAST_POS) && pend;
  assign bus.in_ready = !pend;

  // The frame-boundary tick already decodes position 0, so it must see the value being committed.
  assign show_val = commit ? pend_val : disp_val;

  // The very first tick after reset lights position 0 instead of advancing past it.
  always_comb begin
    pos_next = '0;
    if (scanning && (pos != LAST_POS)) pos_next = pos + pos_t'(1);
  end

  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int i = 4; i >= 0; i--) begin
      run          = run && (show_val.digits[i*4 +: 4] == 4'd0);
      lead_zero[i] = run;
    end
  end

  assign cur_digit = digit_at(show_val.digits, pos_next);

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (digit_seg)
  );

  always_comb begin
    seg_next = digit_seg;
    if (pos_next == LAST_POS) begin
      seg_next = show_val.sign ? SEG_MINUS : SEG_BLANK;
    end else if ((pos_next != '0) && blank_lz && lead_zero[pos_next]) begin
      seg_next = SEG_BLANK;
    end
  end

  assign an_next = ~(6'd1 << pos_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      scanning  <= 1'b0;
      pos       <= '0;
      pend      <= 1'b0;
      pend_val  <= '0;
      disp_val  <= '0;
      an        <= '1;
      seg       <= SEG_BLANK;
    end else begin
      prescaler <= tick ? '0 : prescaler + 16'd1;
      if (bus.in_valid && !pend) begin
        pend_val <= {bus.negative, bus.digits};
        pend     <= 1'b1;
      end
      if (tick) begin
        scanning <= 1'b1;
        pos      <= pos_next;
        an       <= an_next;
        seg      <= seg_next;
        if (commit) begin
          disp_val <= pend_val;
          pend     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboard bench for bcd_7seg_scan: each load queues the expected frame, and a
// monitor pops one entry every time the lit position changes.
module tb_bcd_7seg_scan;

  localparam int CLK_DIV = 4;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        blank_lz = 1'b1;
  logic [5:0]  an;
  logic [6:0]  seg;

  int          checks = 0;
  int          errors = 0;

  logic [12:0] exp_q[$];
  logic [12:0] mon_entry;
  logic [5:0]  mon_prev = 6'h3F;
  int          mon_hold = 0;
  logic [5:0]  last_an  = 6'h3F;

  logic        mdl_sign   = 1'b0;
  logic [19:0] mdl_digits = '0;

  bcd_7seg_scan_if bus();

  bcd_7seg_scan #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] patOf(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h06;
    endcase
  endfunction

  function automatic logic [12:0] expEntry(input int p, input logic sgn, input logic [19:0] d, input logic blz);
    logic [6:0] s;
    bit nz = 1'b0;
    for (int k = 4; k >= p; k--) begin
      if (d[k*4 +: 4] != 4'd0) nz = 1'b1;
    end
    if (p == 5)              s = sgn ? 7'h3F : 7'h7F;
    else if (p == 0)         s = patOf(d[3:0]);
    else if (blz && !nz)     s = 7'h7F;
    else                     s = patOf(d[p*4 +: 4]);
    return {~(6'b1 << p), s};
  endfunction

  task automatic pushFrame(input logic sgn, input logic [19:0] d, input logic blz);
    for (int p = 0; p < 6; p++) exp_q.push_back(expEntry(p, sgn, d, blz));
  endtask

  // Every change of the lit position consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!$isunknown(an) && (an !== mon_prev)) begin
      if (an !== 6'h3F) begin
        if (mon_prev !== 6'h3F) checkOutput("hold_cycles", 32'(mon_hold), CLK_DIV);
        checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_entry = exp_q.pop_front();
          checkOutput("scan_an", 32'(an), 32'(mon_entry[12:7]));
          checkOutput("scan_seg", 32'(seg), 32'(mon_entry[6:0]));
        end
      end
      mon_prev = an;
      mon_hold = 1;
    end else begin
      mon_hold++;
    end
  end

  task automatic waitPos5();
    bit seen = 1'b0;
    for (int i = 0; (i < 6*CLK_DIV + 8) && !seen; i++) begin
      @(negedge clk);
      if ((an === 6'b011111) && (last_an !== 6'b011111)) seen = 1'b1;
      last_an = an;
    end
    checkOutput("pos5_reached", 32'(seen), 1);
  endtask

  task automatic doReset(input int n);
    bit seen = 1'b0;
    int cyc = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
    checkOutput("rst_an", 32'(an), 'h3F);
    checkOutput("rst_seg", 32'(seg), 'h7F);
    checkOutput("rst_ready", 32'(bus.in_ready), 1);
    exp_q.delete();
    mdl_sign   = 1'b0;
    mdl_digits = '0;
    pushFrame(mdl_sign, mdl_digits, blank_lz);
    reset = 1'b0;
    for (int i = 1; (i <= 3*CLK_DIV) && !seen; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("ready_after_rst", 32'(bus.in_ready), 1);
      if (an !== 6'h3F) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    checkOutput("first_tick_cycles", 32'(cyc), CLK_DIV);
  endtask

  task automatic idleFrame();
    waitPos5();
    checkOutput("ready_idle", 32'(bus.in_ready), 1);
    pushFrame(mdl_sign, mdl_digits, blank_lz);
  endtask

  // Loads during the sign position so the commit lands on the boundary that ends this frame.
  task automatic applyStimulus(input logic sgn, input logic [19:0] d, input logic blz, input bit holdSecond);
    waitPos5();
    checkOutput("ready_idle", 32'(bus.in_ready), 1);
    blank_lz     = blz;
    bus.in_valid = 1'b1;
    bus.negative = sgn;
    bus.digits   = d;
    mdl_sign     = sgn;
    mdl_digits   = d;
    pushFrame(mdl_sign, mdl_digits, blz);
    @(negedge clk);
    checkOutput("ready_low", 32'(bus.in_ready), 0);
    if (holdSecond) begin
      bus.negative = ~sgn;
      bus.digits   = 20'h99999;
      repeat (2) begin
        @(negedge clk);
        checkOutput("ready_held", 32'(bus.in_ready), 0);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic resetWithPending();
    waitPos5();
    checkOutput("ready_idle", 32'(bus.in_ready), 1);
    blank_lz     = 1'b1;
    bus.in_valid = 1'b1;
    bus.negative = 1'b1;
    bus.digits   = 20'h54321;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("ready_pend", 32'(bus.in_ready), 0);
    doReset(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the run completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.negative = 1'b0;
    bus.digits   = '0;

    doReset(2);
    idleFrame();
    applyStimulus(1'b1, 20'h12345, 1'b1, 1'b0);
    applyStimulus(1'b0, 20'h00070, 1'b1, 1'b0);
    applyStimulus(1'b0, 20'h00070, 1'b0, 1'b0);
    applyStimulus(1'b0, 20'h0A000, 1'b1, 1'b0);
    applyStimulus(1'b1, 20'h00042, 1'b1, 1'b1);
    applyStimulus(1'b0, 20'h99999, 1'b1, 1'b0);
    applyStimulus(1'b1, 20'h00000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 20'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    resetWithPending();
    idleFrame();
    idleFrame();
    applyStimulus(1'b0, 20'h00305, 1'b1, 1'b0);
    waitPos5();
    @(negedge clk);
    checkOutput("sb_drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scan.md
# bcd_7seg_scan

Multiplexed seven-segment display driver that consumes the sign flag and five BCD digits produced by the 16-bit binary-to-BCD converter and shows them on a six-position common-anode display. It double-buffers the value through a valid/ready handshake and commits new values only at frame boundaries, so the display never tears. It scans one position per refresh tick, blanks leading zeros and drives a minus sign in the leftmost position.

## Interface
- CLK_DIV, 50000: clock cycles per display position (refresh tick period); legal range 2..65535.
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream has a new value on negative/digits.
- in_ready  out  1  block can accept a value this cycle.
- negative  in  1  sign flag, 1 = negative.
- digits  in  20  BCD digits, [3:0] = ones … [19:16] = ten-thousands.
- blank_lz  in  1  1 = suppress leading zeros (sampled live, not buffered).
- an  out  6  anode enables, active-low, an[0] = ones position, an[5] = sign position.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Prescaler counts 0..CLK_DIV-1, wraps; tick = prescaler at CLK_DIV-1.
- Position index pos counts 0..5; advances on tick, 5 wraps to 0.
- Pending buffer (sign + 20 bits + pend flag): in_ready = !pend. Handshake accept when in_valid && in_ready: capture inputs, set pend.
- Display register (sign + 20 bits): on tick with pos == 5 (frame boundary) and pend set, copy pending into display, clear pend. in_valid while pend is set is ignored (no capture, no error).
- Position decode for display position p:
  - p = 0: digit 0, never blanked.
  - p = 1..4: blank if blank_lz and that digit and all higher digits are 0.
  - p = 5: SEG_MINUS if sign, else SEG_BLANK. Sign shown even if value is 0.
  - Digit > 9: SEG_E (no blanking applies to it; it also counts as non-zero for lower digits).
- Exactly one anode low at a time once scanning starts.

## Timing
- Reset: prescaler 0, pos 0, pend 0, display register 0 (sign 0), an = 6'b111111, seg = 7'b1111111, in_ready = 1 in the cycle after reset deasserts.
- an/seg are registered: on the cycle a tick occurs, the next cycle shows the new pos. First tick after reset is CLK_DIV cycles after reset deasserts; an goes 6'b111110 one cycle later. Thereafter each position is held exactly CLK_DIV cycles.
- Accept to in_ready low: 1 cycle (pend registered).
- Commit: display register updates on the frame-boundary tick; new value first appears on position 0 the next cycle; in_ready returns 1 that same next cycle. Worst-case accept-to-visible latency 6·CLK_DIV+1 cycles.
- Accept and commit in the same cycle cannot occur (ready is low while pend set).
- Reset mid-frame or with pend set: everything returns to reset values; pending value discarded.
- blank_lz change takes effect on the next registered seg update.

## Structure
- Package seg7_pkg: SEG_DIGIT[0:9] patterns, SEG_MINUS (7'b0111111), SEG_BLANK (7'b1111111), SEG_E (7'b0000110), NUM_POS = 6.
- Sub-module bcd_to_7seg: combinational 4-bit digit -> 7-bit active-low pattern, SEG_E for 10..15. Top holds prescaler, pos counter, handshake buffers and blanking logic.

## Test plan
- Reset, CLK_DIV=4, no load: after 4 cycles an = 111110, seg = SEG_DIGIT[0]; positions 1..5 blank with blank_lz = 1, each held 4 cycles, pos wraps 5 -> 0.
- Load negative=1, digits=0x12345 (12345): in_ready drops next cycle; after frame boundary, scan shows 5,4,3,2,1,minus on an[0..5]; in_ready returns 1.
- Load negative=0, digits=0x00070, blank_lz=1: positions 0,1 show 0,7; positions 2..5 blank. Same with blank_lz=0: positions 2..4 show 0.
- Digit 0xA in position 3 (digits=0x0A000): position 3 shows SEG_E, position 4 blank, positions 0..2 show 0.
- Back-to-back in_valid with different values while pend set: only first value displayed; second ignored until in_ready = 1, then accepted.
- Assert reset for one cycle mid-frame with pend set: an = 111111, seg = 1111111, in_ready = 1, old display value replaced by 0, scan restarts after CLK_DIV cycles.
